// File: rtl/pixel_block_loader_pkg.sv
// -----------------------------------------------------------------------------
// pixel_block_loader_pkg
// Shared constants for the pixel block loader: default block geometry, the
// default interpolator run window, the loader FSM state encoding and a small
// helper that sizes the pixel index counter for a given block edge.
// -----------------------------------------------------------------------------
package pixel_block_loader_pkg;

    // Default block edge in pixels (block = BLK*BLK pixels)
    localparam int BLK_DEF        = 15;
    // Default pixel width in bits
    localparam int PW_DEF         = 8;
    // Default number of cycles the interpolator is released per block
    localparam int RUN_CYCLES_DEF = 56;

    // Loader FSM encoding, kept as plain constants for legacy tool flows
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Width of a counter that indexes every pixel of a blk x blk block
    function automatic int idx_width(input int blk);
        int n;
        n = blk * blk;
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/pixel_block_loader_timer.sv
// -----------------------------------------------------------------------------
// pixel_block_loader_timer
// Run-window timer. A one-cycle i_start arms it; it then stays active for
// exactly RUN_CYCLES cycles and raises o_done (registered) during the last of
// them, so the consumer can act on the edge that ends the window.
//
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_start   arm the timer (first cycle of the window follows this edge)
//   o_active  high while the window is open
//   o_done    high during the final cycle of the window
// -----------------------------------------------------------------------------
module pixel_block_loader_timer #(
    parameter int RUN_CYCLES = 56
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    output logic o_active,
    output logic o_done
);

    localparam int CNT_W = (RUN_CYCLES < 2) ? 1 : $clog2(RUN_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_active;
    logic             r_done;

    // Down-counter; done is pre-computed one cycle ahead so it is registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= CNT_W'(RUN_CYCLES - 1);
            r_active <= 1'b1;
            r_done   <= (RUN_CYCLES == 1);
        end else if (r_active) begin
            if (r_done) begin
                r_active <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_done <= (r_cnt == CNT_W'(1));
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_active = r_active;
    assign o_done   = r_done;

endmodule

// File: rtl/pixel_block_loader.sv
// -----------------------------------------------------------------------------
// pixel_block_loader
// Write-side front end for subpixel_interpolation. Accepts a raster-order pixel
// stream over valid/ready, packs a BLK x BLK block into in_buffer (pixel k at
// in_buffer[PW*k +: PW]), holds the interpolator in reset while loading, then
// releases it for RUN_CYCLES cycles before accepting the next block.
//
// Ports:
//   clk         clock
//   rst         asynchronous active-low reset
//   pix_in      pixel data, row-major, row 0 col 0 first
//   pix_valid   pix_in valid
//   pix_sof     start-of-block marker, qualified by pix_valid
//   pix_ready   loader accepts a pixel this cycle (combinational)
//   in_buffer   packed block for subpixel_interpolation.in_buffer
//   interp_rst  active-low reset to subpixel_interpolation
//   busy        high while the interpolator runs
//   blk_count   completed blocks, wraps at 16 bits
// -----------------------------------------------------------------------------
module pixel_block_loader
    import pixel_block_loader_pkg::*;
#(
    parameter int BLK        = pixel_block_loader_pkg::BLK_DEF,
    parameter int PW         = pixel_block_loader_pkg::PW_DEF,
    parameter int RUN_CYCLES = pixel_block_loader_pkg::RUN_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PW-1:0]         pix_in,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    output logic                  pix_ready,
    output logic [BLK*BLK*PW-1:0] in_buffer,
    output logic                  interp_rst,
    output logic                  busy,
    output logic [15:0]           blk_count
);

    localparam int                BLK_PIX  = BLK * BLK;
    localparam int                BUF_W    = BLK_PIX * PW;
    localparam int                IDX_W    = idx_width(BLK);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLK_PIX - 1);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [BUF_W-1:0] r_in_buffer;
    logic             r_interp_rst;
    logic             r_busy;
    logic [15:0]      r_blk_count;

    logic             w_xfer;
    logic [IDX_W-1:0] w_wr_idx;
    logic             w_last_pix;
    logic             w_run_done;
    logic             w_run_active;

    // Ready is gated by rst directly so it drops the moment reset asserts
    assign pix_ready  = rst & (r_state == ST_LOAD);
    assign w_xfer     = pix_valid & pix_ready;
    // A start-of-block marker always lands in byte 0, whatever idx says
    assign w_wr_idx   = pix_sof ? {IDX_W{1'b0}} : r_idx;
    // A sof on the final index restarts the block instead of completing it
    assign w_last_pix = w_xfer & ~pix_sof & (r_idx == IDX_LAST);

    pixel_block_loader_timer #(
        .RUN_CYCLES (RUN_CYCLES)
    ) u_run_timer (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_start  (w_last_pix),
        .o_active (w_run_active),
        .o_done   (w_run_done)
    );

    // Loader FSM: packs pixels during LOAD, holds everything frozen during RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_LOAD;
            r_idx        <= {IDX_W{1'b0}};
            r_in_buffer  <= {BUF_W{1'b0}};
            r_interp_rst <= 1'b0;
            r_busy       <= 1'b0;
            r_blk_count  <= 16'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_in_buffer[w_wr_idx*PW +: PW] <= pix_in;
                        if (pix_sof) begin
                            r_idx <= IDX_W'(1);
                        end else if (r_idx == IDX_LAST) begin
                            r_idx        <= {IDX_W{1'b0}};
                            r_state      <= ST_RUN;
                            r_interp_rst <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_idx <= r_idx;
                    end
                end
                ST_RUN: begin
                    // The timer's done marks the last cycle of the window
                    if (w_run_done && w_run_active) begin
                        r_state      <= ST_LOAD;
                        r_interp_rst <= 1'b0;
                        r_busy       <= 1'b0;
                        r_blk_count  <= r_blk_count + 16'd1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state      <= ST_LOAD;
                    r_idx        <= {IDX_W{1'b0}};
                    r_interp_rst <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign in_buffer  = r_in_buffer;
    assign interp_rst = r_interp_rst;
    assign busy       = r_busy;
    assign blk_count  = r_blk_count;

endmodule
